// File: rtl/eth_rx_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_frame_buffer
// Brief    : Store-and-forward Ethernet RX frame buffer. Frames are written
//            speculatively, published on a good commit, rolled back on drop,
//            and replayed downstream as gap-free bursts gated by out_ready.
//            Optional runt filter: define ETH_RX_FRAME_BUFFER_RUNT_FILTER_EN.
// Revision : 1.0  initial release
// ============================================================================
module eth_rx_frame_buffer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 1024,
  parameter  int MAX_FRAMES = 32,
  localparam int BV         = $clog2(DATA_WIDTH/8) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_start,
  input  logic                  in_data_valid,
  input  logic [BV-1:0]         in_bytes_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_commit,
  input  logic                  in_drop,
  input  logic                  out_ready,
  output logic                  out_start,
  output logic                  out_data_valid,
  output logic [BV-1:0]         out_bytes_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_commit,
  output logic [63:0]           perf_frames_fwd,
  output logic [63:0]           perf_drop_overflow,
  output logic [63:0]           perf_drop_mac
`ifdef ETH_RX_FRAME_BUFFER_RUNT_FILTER_EN
  ,
  output logic [63:0]           perf_drop_runt
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int FW  = $clog2(MAX_FRAMES);
  localparam int FPW = FW + 1;
  localparam int RW  = BV + DATA_WIDTH;

  localparam logic [PW-1:0]  C_DEPTH  = PW'(DEPTH);
  localparam logic [FPW-1:0] C_FRAMES = FPW'(MAX_FRAMES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [RW-1:0]  mem      [DEPTH];
  logic [PW-1:0]  desc_mem [MAX_FRAMES];

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, wr_commit_ptr_q, wr_commit_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d, len_q, len_d, count_q, count_d;
  logic           open_q, open_d, ovf_q, ovf_d;
  logic [FPW-1:0] dq_wr_q, dq_wr_d, dq_rd_q, dq_rd_d;
  logic [1:0]     state_q, state_d;
  logic           out_start_q, out_start_d, out_valid_q, out_valid_d;
  logic           out_commit_q, out_commit_d;
  logic [RW-1:0]  out_word_q, out_word_d;
  logic [63:0]    fwd_q, fwd_d, dovf_q, dovf_d, dmac_q, dmac_d;

  logic [PW-1:0]  base_ptr, base_len, ptr_n, len_n, desc_len;
  logic           base_open, base_ovf, ovf_n, data_full, dq_full, dq_empty;
  logic           wr_en, push, pop, rd_en, desc_avail, ovf_inc;
  logic [1:0]     mac_inc;

`ifdef ETH_RX_FRAME_BUFFER_RUNT_FILTER_EN
  logic [15:0]    bytes_q, bytes_d, base_bytes;
  logic [16:0]    bytes_sum;
  logic [63:0]    drunt_q, drunt_d;
  logic           runt_inc;
`endif

  assign dq_full    = (dq_wr_q - dq_rd_q) == C_FRAMES;
  assign dq_empty   = (dq_wr_q == dq_rd_q);
  // A commit in this cycle is visible to the reader immediately (bypass).
  assign desc_avail = ~dq_empty | push;
  assign desc_len   = dq_empty ? len_n : desc_mem[dq_rd_q[FW-1:0]];

  // Write side: a restart behaves as a fresh frame base, then the data word,
  // then commit/drop resolution on the post-write length.
  always_comb begin
    base_ptr        = in_start ? wr_commit_ptr_q : wr_ptr_q;
    base_open       = in_start | open_q;
    base_len        = in_start ? '0 : len_q;
    base_ovf        = in_start ? 1'b0 : ovf_q;
    data_full       = (base_ptr - rd_ptr_q) == C_DEPTH;
    wr_en           = base_open & in_data_valid & ~data_full;
    ovf_n           = base_ovf | (base_open & in_data_valid & data_full);
    ptr_n           = base_ptr + PW'(wr_en);
    len_n           = base_len + PW'(wr_en);
    mac_inc         = {1'b0, in_start & open_q};
    ovf_inc         = 1'b0;
    push            = 1'b0;
    wr_ptr_d        = ptr_n;
    len_d           = len_n;
    ovf_d           = ovf_n;
    open_d          = base_open;
    wr_commit_ptr_d = wr_commit_ptr_q;
`ifdef ETH_RX_FRAME_BUFFER_RUNT_FILTER_EN
    base_bytes      = in_start ? '0 : bytes_q;
    bytes_sum       = {1'b0, base_bytes} +
                      ((base_open & in_data_valid) ? 17'(in_bytes_valid) : 17'd0);
    bytes_d         = bytes_sum[16] ? 16'hFFFF : bytes_sum[15:0];
    runt_inc        = 1'b0;
`endif
    if (base_open && in_drop) begin
      wr_ptr_d = wr_commit_ptr_q;
      open_d   = 1'b0;
      mac_inc  = mac_inc + 2'd1;
    end else if (base_open && in_commit) begin
      open_d = 1'b0;
      if (len_n == '0) begin
        wr_ptr_d = wr_commit_ptr_q;
      end else if (ovf_n || dq_full) begin
        wr_ptr_d = wr_commit_ptr_q;
        ovf_inc  = 1'b1;
`ifdef ETH_RX_FRAME_BUFFER_RUNT_FILTER_EN
      end else if (bytes_d < 16'd60) begin
        wr_ptr_d = wr_commit_ptr_q;
        runt_inc = 1'b1;
`endif
      end else begin
        push            = 1'b1;
        wr_commit_ptr_d = ptr_n;
      end
    end
    dq_wr_d = dq_wr_q + FPW'(push);
    dmac_d  = dmac_q + 64'(mac_inc);
    dovf_d  = dovf_q + 64'(ovf_inc);
`ifdef ETH_RX_FRAME_BUFFER_RUNT_FILTER_EN
    drunt_d = drunt_q + 64'(runt_inc);
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[base_ptr[AW-1:0]] <= {in_bytes_valid, in_data};
    if (push)  desc_mem[dq_wr_q[FW-1:0]] <= len_n;
  end

  // Read FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Read FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (desc_avail && out_ready) state_d = S_DATA;
      S_DATA:   if (count_q == PW'(1)) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Read FSM: outputs and read datapath
  always_comb begin
    out_start_d  = 1'b0;
    out_commit_d = 1'b0;
    out_valid_d  = 1'b0;
    rd_en        = 1'b0;
    pop          = 1'b0;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    fwd_d        = fwd_q;
    case (state_q)
      S_IDLE: begin
        if (desc_avail && out_ready) begin
          out_start_d = 1'b1;
          count_d     = desc_len;
          pop         = 1'b1;
        end
      end
      S_DATA: begin
        rd_en       = 1'b1;
        out_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + PW'(1);
        count_d     = count_q - PW'(1);
      end
      S_COMMIT: begin
        out_commit_d = 1'b1;
        fwd_d        = fwd_q + 64'd1;
      end
      default: ;
    endcase
    dq_rd_d    = dq_rd_q + FPW'(pop);
    out_word_d = rd_en ? mem[rd_ptr_q[AW-1:0]] : out_word_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      wr_commit_ptr_q <= '0;
      rd_ptr_q        <= '0;
      len_q           <= '0;
      count_q         <= '0;
      open_q          <= 1'b0;
      ovf_q           <= 1'b0;
      dq_wr_q         <= '0;
      dq_rd_q         <= '0;
      out_start_q     <= 1'b0;
      out_valid_q     <= 1'b0;
      out_commit_q    <= 1'b0;
      out_word_q      <= '0;
      fwd_q           <= '0;
      dovf_q          <= '0;
      dmac_q          <= '0;
`ifdef ETH_RX_FRAME_BUFFER_RUNT_FILTER_EN
      bytes_q         <= '0;
      drunt_q         <= '0;
`endif
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      wr_commit_ptr_q <= wr_commit_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      len_q           <= len_d;
      count_q         <= count_d;
      open_q          <= open_d;
      ovf_q           <= ovf_d;
      dq_wr_q         <= dq_wr_d;
      dq_rd_q         <= dq_rd_d;
      out_start_q     <= out_start_d;
      out_valid_q     <= out_valid_d;
      out_commit_q    <= out_commit_d;
      out_word_q      <= out_word_d;
      fwd_q           <= fwd_d;
      dovf_q          <= dovf_d;
      dmac_q          <= dmac_d;
`ifdef ETH_RX_FRAME_BUFFER_RUNT_FILTER_EN
      bytes_q         <= bytes_d;
      drunt_q         <= drunt_d;
`endif
    end
  end

  assign out_start          = out_start_q;
  assign out_data_valid     = out_valid_q;
  assign out_bytes_valid    = out_word_q[RW-1:DATA_WIDTH];
  assign out_data           = out_word_q[DATA_WIDTH-1:0];
  assign out_commit         = out_commit_q;
  assign perf_frames_fwd    = fwd_q;
  assign perf_drop_overflow = dovf_q;
  assign perf_drop_mac      = dmac_q;
`ifdef ETH_RX_FRAME_BUFFER_RUNT_FILTER_EN
  assign perf_drop_runt     = drunt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_rx_frame_buffer
// Brief    : Scoreboard bench for eth_rx_frame_buffer (DEPTH=16, MAX_FRAMES=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_eth_rx_frame_buffer;
  localparam int DW = 32;
  localparam int BV = $clog2(DW/8) + 1;
  typedef logic [BV+DW-1:0] word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_start = 1'b0, in_data_valid = 1'b0, in_commit = 1'b0, in_drop = 1'b0;
  logic [BV-1:0] in_bytes_valid = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          out_start, out_data_valid, out_commit;
  logic [BV-1:0] out_bytes_valid;
  logic [DW-1:0] out_data;
  logic [63:0]   perf_frames_fwd, perf_drop_overflow, perf_drop_mac;
`ifdef ETH_RX_FRAME_BUFFER_RUNT_FILTER_EN
  logic [63:0]   perf_drop_runt;
`endif

  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc   = 0;
  word_t exp_q[$];
  int    len_q[$];

  eth_rx_frame_buffer #(.DATA_WIDTH(DW), .DEPTH(16), .MAX_FRAMES(4)) dut (
    .clk(clk), .rst(rst),
    .in_start(in_start), .in_data_valid(in_data_valid),
    .in_bytes_valid(in_bytes_valid), .in_data(in_data),
    .in_commit(in_commit), .in_drop(in_drop), .out_ready(out_ready),
    .out_start(out_start), .out_data_valid(out_data_valid),
    .out_bytes_valid(out_bytes_valid), .out_data(out_data),
    .out_commit(out_commit), .perf_frames_fwd(perf_frames_fwd),
    .perf_drop_overflow(perf_drop_overflow), .perf_drop_mac(perf_drop_mac)
`ifdef ETH_RX_FRAME_BUFFER_RUNT_FILTER_EN
    , .perf_drop_runt(perf_drop_runt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_start = 0; in_data_valid = 0; in_commit = 0; in_drop = 0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    len_q.delete();
  endtask

  // mode: 0 commit with last word, 1 drop after last word, 2 leave open
  task automatic send_frame(input int nwords, input int last_bv, input int mode,
                            input bit expect_fwd, output int t_commit);
    word_t w;
    @(posedge clk); #1;
    in_start = 1'b1;
    @(posedge clk); #1;
    in_start = 1'b0;
    t_commit = -1;
    for (int i = 0; i < nwords; i++) begin
      w[DW-1:0]       = $urandom;
      w[DW+BV-1:DW]   = (i == nwords-1) ? BV'(last_bv) : BV'(DW/8);
      in_data_valid   = 1'b1;
      in_bytes_valid  = w[DW+BV-1:DW];
      in_data         = w[DW-1:0];
      if (i == nwords-1 && mode == 0) begin
        in_commit = 1'b1;
        t_commit  = cyc;
      end
      if (expect_fwd) exp_q.push_back(w);
      @(posedge clk); #1;
    end
    in_data_valid = 1'b0;
    in_commit     = 1'b0;
    if (mode == 1) begin
      in_drop = 1'b1;
      @(posedge clk); #1;
      in_drop = 1'b0;
    end
    if (expect_fwd) len_q.push_back(nwords);
  endtask

  task automatic recv_frame(input string nm, input int budget, output int s_cyc);
    bit    got;
    int    n;
    word_t e;
    got   = 1'b0;
    s_cyc = -1;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (out_start === 1'b1) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s start: no out_start within %0d cycles", nm, budget);
      return;
    end
    s_cyc = cyc;
    n = (len_q.size() > 0) ? len_q.pop_front() : 0;
    for (int w = 0; w < n; w++) begin
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      n_cmp++;
      if (out_data_valid !== 1'b1 || out_start !== 1'b0 || out_commit !== 1'b0 ||
          {out_bytes_valid, out_data} !== e) begin
        n_err++;
        $display("FAIL %s word%0d: got v=%b bv=%0d d=%h, want v=1 bv=%0d d=%h",
                 nm, w, out_data_valid, out_bytes_valid, out_data, e[DW+BV-1:DW], e[DW-1:0]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (out_commit !== 1'b1 || out_data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s commit: got commit=%b valid=%b, want 1/0", nm, out_commit, out_data_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({out_start, out_data_valid, out_commit, out_bytes_valid, out_data} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, want 0",
               {out_start, out_data_valid, out_commit, out_bytes_valid, out_data});
    end
    n_cmp++;
    if ({perf_frames_fwd, perf_drop_overflow, perf_drop_mac} !== '0) begin
      n_err++;
      $display("FAIL reset_counters: got %0d/%0d/%0d, want 0/0/0",
               perf_frames_fwd, perf_drop_overflow, perf_drop_mac);
    end
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({out_start, out_data_valid, out_commit} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b, want 000", {out_start, out_data_valid, out_commit});
    end
  endtask

  task automatic test_single_frame();
    int tc, sc;
    do_reset();
    out_ready = 1'b1;
    send_frame(16, 2, 0, 1'b1, tc);
    recv_frame("single", 4, sc);
    n_cmp++;
    if (sc != tc + 1) begin
      n_err++;
      $display("FAIL single_latency: out_start at %0d, want %0d", sc, tc + 1);
    end
    n_cmp++;
    if (cyc != tc + 18) begin
      n_err++;
      $display("FAIL single_commit_cycle: out_commit at %0d, want %0d", cyc, tc + 18);
    end
    @(negedge clk);
    n_cmp++;
    if (perf_frames_fwd !== 64'd1) begin
      n_err++;
      $display("FAIL single_fwd_count: got %0d, want 1", perf_frames_fwd);
    end
  endtask

  task automatic test_mac_drop();
    int tc, sc;
    bit seen;
    do_reset();
    out_ready = 1'b1;
    send_frame(10, 4, 1, 1'b0, tc);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_start !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen || perf_drop_mac !== 64'd1) begin
      n_err++;
      $display("FAIL mac_drop: got start_seen=%b drop_mac=%0d, want 0/1", seen, perf_drop_mac);
    end
    send_frame(8, 3, 0, 1'b1, tc);
    recv_frame("after_drop", 4, sc);
  endtask

  task automatic test_overflow();
    int tc, sc;
    bit seen;
    do_reset();
    send_frame(12, 4, 0, 1'b1, tc);
    send_frame(10, 4, 0, 1'b0, tc);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (perf_drop_overflow !== 64'd1 || out_start !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_drop: got drop_ovf=%0d start=%b, want 1/0",
               perf_drop_overflow, out_start);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    recv_frame("overflow_keep", 4, sc);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_start !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL overflow_extra: got extra out_start, want none");
    end
  endtask

  task automatic test_back_to_back();
    int tc, sc, last_c;
    bit seen;
    do_reset();
    for (int f = 0; f < 5; f++) send_frame(2, 4, 0, f < 4, tc);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (perf_drop_overflow !== 64'd1) begin
      n_err++;
      $display("FAIL queue_full_drop: got %0d, want 1", perf_drop_overflow);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    last_c = -1;
    for (int f = 0; f < 4; f++) begin
      recv_frame("b2b", 4, sc);
      if (f > 0) begin
        n_cmp++;
        if (sc != last_c + 1) begin
          n_err++;
          $display("FAIL b2b_gap%0d: out_start at %0d, want %0d", f, sc, last_c + 1);
        end
      end
      last_c = cyc;
    end
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_start !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen || perf_frames_fwd !== 64'd4 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_total: got extra=%b fwd=%0d left=%0d, want 0/4/0",
               seen, perf_frames_fwd, exp_q.size());
    end
  endtask

  task automatic test_restart_and_reset();
    int tc;
    bit got;
    word_t e;
    do_reset();
    out_ready = 1'b1;
    send_frame(3, 4, 2, 1'b0, tc);
    send_frame(5, 4, 0, 1'b1, tc);
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge clk);
      if (out_start === 1'b1) got = 1'b1;
    end
    n_cmp++;
    if (!got || perf_drop_mac !== 64'd1) begin
      n_err++;
      $display("FAIL restart: got start=%b drop_mac=%0d, want 1/1", got, perf_drop_mac);
    end
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      n_cmp++;
      if (out_data_valid !== 1'b1 || {out_bytes_valid, out_data} !== e) begin
        n_err++;
        $display("FAIL restart_word%0d: got v=%b d=%h, want v=1 d=%h",
                 w, out_data_valid, out_data, e[DW-1:0]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_start, out_data_valid, out_commit, out_bytes_valid, out_data} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_frame: got %h, want 0",
               {out_start, out_data_valid, out_commit, out_bytes_valid, out_data});
    end
    @(posedge clk); #1 rst = 1'b0;
    got = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_commit !== 1'b0 || out_start !== 1'b0) got = 1'b1;
    end
    n_cmp++;
    if (got) begin
      n_err++;
      $display("FAIL reset_no_commit: got commit/start after reset, want none");
    end
    exp_q.delete();
    len_q.delete();
  endtask

`ifdef ETH_RX_FRAME_BUFFER_RUNT_FILTER_EN
  task automatic test_runt();
    int tc, sc;
    do_reset();
    out_ready = 1'b1;
    send_frame(15, 3, 0, 1'b0, tc);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (perf_drop_runt !== 64'd1 || perf_frames_fwd !== 64'd0) begin
      n_err++;
      $display("FAIL runt_59: got runt=%0d fwd=%0d, want 1/0", perf_drop_runt, perf_frames_fwd);
    end
    send_frame(15, 4, 0, 1'b1, tc);
    recv_frame("runt_60", 4, sc);
    @(negedge clk);
    n_cmp++;
    if (perf_frames_fwd !== 64'd1) begin
      n_err++;
      $display("FAIL runt_60_fwd: got %0d, want 1", perf_frames_fwd);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_mac_drop();
    test_overflow();
    test_back_to_back();
    test_restart_and_reset();
`ifdef ETH_RX_FRAME_BUFFER_RUNT_FILTER_EN
    test_runt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
